memory_game_core: RTL and testbench
===================================

# memory_game_core

Parametrised successor to the fixed 4-LED memory-game state machine. Generates a growing pseudo-random sequence over `NUM_CH` channels, plays it on `o_led`, checks the player's button presses, and tracks the current and best score. It adds a per-press input timeout, a win condition at `MAX_LEN`, and a high-score register. It sits between the per-button debounce filters and the score-to-seven-segment decoder in the top level.

## Interface
- `NUM_CH`, 4: number of buttons/LEDs; 2..16.
- `MAX_LEN`, 15: sequence length that wins the game; 1..255.
- `CLK_PER_STEP`, 25000000: LED on-time per sequence element, in cycles; ≥2.
- `TIMEOUT`, 150000000: maximum cycles allowed between presses in the input phase.
- `SCORE_W`, derived as `$clog2(MAX_LEN+1)`: score width.
- `i_clk` in 1: system clock; all logic on its rising edge.
- `i_rst_n` in 1: reset, synchronous and active-low.
- `i_start` in 1: debounced start level; acts on its rising edge.
- `i_btn` in NUM_CH: debounced button levels, active-high.
- `o_led` in NUM_CH, direction out: LED drive, one-hot or zero except in the WIN flash.
- `o_score` out SCORE_W: rounds completed in the current game.
- `o_high_score` out SCORE_W: best `o_score` since reset.
- `o_busy` out 1: high in any state other than IDLE, WIN and LOSE.
- `o_win` out 1: high in WIN.
- `o_lose` out 1: high in LOSE.

## Operation
- **Reset.** All outputs are 0. The state is IDLE. The LFSR is 16'hACE1. Sequence memory is not cleared. The high score is cleared only by reset.
- **LFSR.** 16-bit Galois, taps 16,14,13,11. It advances every cycle in every state, so player timing seeds randomness. A new element is `lfsr % NUM_CH`.
- **Edge detection.** `i_start` and `i_btn` each pass through a 1-cycle previous-value register. A rise is `cur & ~prev`.
- **IDLE / WIN / LOSE.** A rise on `i_start` clears `o_score`, `o_win` and `o_lose` and moves to ADD. All other inputs are ignored.
- **ADD.** Writes the new element to `seq[o_score]`, clears the play index and moves to SHOW_ON. This state lasts 1 cycle.
- **SHOW_ON.** Drives the one-hot `o_led` for `seq[idx]` for `CLK_PER_STEP` cycles, then moves to SHOW_OFF.
- **SHOW_OFF.** Drives `o_led` to 0 for `CLK_PER_STEP/2` cycles.
  - If `idx == o_score`, it clears `idx` and the timeout counter and moves to WAIT_IN.
  - Otherwise it increments `idx` and returns to SHOW_ON.
- **WAIT_IN.** `o_led` echoes the registered `i_btn`. The timeout counter increments every cycle.
  - No rise and the counter reaches `TIMEOUT-1`: move to LOSE.
  - Rise on more than one bit in the same cycle: move to LOSE.
  - Single rise on channel ≠ `seq[idx]`: move to LOSE.
  - Single rise on channel = `seq[idx]`, with `idx < o_score`: increment `idx`, clear the timeout counter and stay in WAIT_IN.
  - Single rise on channel = `seq[idx]`, with `idx == o_score`: increment `o_score` and move to RELEASE.
- **RELEASE.** Waits until `i_btn == 0`; no timeout applies.
  - If `o_score == MAX_LEN`, move to WIN.
  - Otherwise move to ADD.
- **WIN.** `o_led` is all-ones, toggling every `CLK_PER_STEP` cycles.
- **LOSE.** `o_led` is 0.
- **High score.** Updated on entry to WIN or LOSE: `o_high_score <= max(o_high_score, o_score)`.
- **Arithmetic.** The score never exceeds `MAX_LEN`, so there is no wrap. The timer is `$clog2(max(CLK_PER_STEP, TIMEOUT))` bits.

## Timing
- A rise on `i_start` at cycle t gives `o_busy=1` at t+2: one cycle for the edge register and one for the state update.
- The first LED is on at t+3.
- Sequence playback for score s lasts exactly `(s+1)*(CLK_PER_STEP + CLK_PER_STEP/2)` cycles.
- A button rise is judged in the cycle after the level rises, and the state reacts in the following cycle.
- **Simultaneous events.**
  - A button rise and a timeout expiry in the same cycle: the press wins.
  - Reset asserted in any state: the state is IDLE on the next edge, and all outputs except `seq` are cleared.
- The `i_start` level held high across states is not re-triggered; only a new rise acts.

## Structure
- Package `memory_game_pkg` holds:
  - the state enum (IDLE, ADD, SHOW_ON, SHOW_OFF, WAIT_IN, RELEASE, WIN, LOSE);
  - the LFSR seed and tap constants.
- Sub-module `lfsr16`: free-running Galois LFSR with synchronous active-low reset to the seed, output `o_q[15:0]`.
- Sequence storage is a register array of `MAX_LEN` × `$clog2(NUM_CH)` bits, written only in ADD.

## Test plan
Parameters for all scenarios: `NUM_CH=4`, `MAX_LEN=3`, `CLK_PER_STEP=4`, `TIMEOUT=20`.

1. **Reset values.** Hold `i_rst_n=0` for 3 cycles, then release → all outputs are 0 and the state is IDLE. Pulse `i_btn=4'b0001` → no change.
2. **Full win.** Start, then mirror each played element correctly for 3 rounds, pressing 5 cycles apart.
   - `o_score` steps 1, 2, 3; `o_win=1`; `o_high_score=3`.
   - `o_led` toggles 4'hF/4'h0 every 4 cycles.
3. **Wrong press.** Start. The first element plays. Press a different channel → `o_lose=1`, `o_score=0`, `o_led=0`, `o_busy=0`.
4. **Timeout.** Start, let the first element play, press nothing → LOSE exactly 20 cycles after WAIT_IN entry. Repeat with the press in cycle 19 → no LOSE.
5. **Multi-press and high-score retention.**
   - Reach score 2, then press two buttons in the same cycle → LOSE with `o_high_score=2`.
   - Restart and lose at score 1 → `o_high_score` stays 2.
6. **Reset mid-game.** Assert `i_rst_n=0` during SHOW_ON → next cycle IDLE, `o_led=0`, `o_high_score=0`. A rise on `i_start` starts a new game normally.

Source files
------------

// File: rtl/memory_game_core_pkg.sv
// Shared types and constants for the memory game core.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   state_t    - game FSM state encoding
//   LFSR_SEED  - value the sequence generator restarts from on reset
//   LFSR_TAPS  - Galois feedback mask for taps 16,14,13,11
//   lfsr_next  - one Galois step (right shift, feedback into the tap positions)
package memory_game_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADD      = 3'd1,
        SHOW_ON  = 3'd2,
        SHOW_OFF = 3'd3,
        WAIT_IN  = 3'd4,
        RELEASE  = 3'd5,
        WIN      = 3'd6,
        LOSE     = 3'd7
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Tap 16 is the bit shifted out; taps 14,13,11 map to bits 15,13,12,10
    // of the right-shifting register.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        logic [15:0] shifted;
        shifted = q >> 1;
        return q[0] ? (shifted ^ LFSR_TAPS) : shifted;
    endfunction

endpackage

// File: rtl/memory_game_core_lfsr16.sv
// Free-running 16-bit Galois LFSR used as the sequence randomness source.
// Latency: new value every cycle; o_q is the registered state.
// Backpressure: none; it never stalls, so player timing perturbs the sequence.
//
// Ports:
//   i_clk   - system clock
//   i_rst_n - synchronous active-low reset, loads LFSR_SEED
//   o_q     - current register contents
module lfsr16
    import memory_game_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic [15:0] o_q
);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_q <= LFSR_SEED;
        end else begin
            o_q <= lfsr_next(o_q);
        end
    end

endmodule

// File: rtl/memory_game_core.sv
// Memory game: plays a growing random LED sequence, checks button replay, keeps score/high score.
// Latency: start rise -> busy 2 cycles, first LED 3 cycles; button rise judged 1 cycle after level, state reacts 1 later.
// Backpressure: none; inputs are levels, a per-press timeout forces LOSE if the player stalls.
//
// Ports:
//   i_clk, i_rst_n - clock and synchronous active-low reset
//   i_start        - debounced start level, acts on its rising edge
//   i_btn          - debounced button levels, active-high, one per channel
//   o_led          - LED drive: one-hot during playback, button echo during input, flashing in WIN
//   o_score        - rounds completed in the current game
//   o_high_score   - best score since reset
//   o_busy         - game in progress (not IDLE/WIN/LOSE)
//   o_win, o_lose  - game outcome flags
module memory_game_core
    import memory_game_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int MAX_LEN      = 15,
    parameter int CLK_PER_STEP = 25000000,
    parameter int TIMEOUT      = 150000000,
    localparam int SCORE_W     = $clog2(MAX_LEN + 1)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic [NUM_CH-1:0]  i_btn,
    output logic [NUM_CH-1:0]  o_led,
    output logic [SCORE_W-1:0] o_score,
    output logic [SCORE_W-1:0] o_high_score,
    output logic               o_busy,
    output logic               o_win,
    output logic               o_lose
);

    localparam int IDX_W   = $clog2(NUM_CH);
    localparam int TMR_MAX = (CLK_PER_STEP > TIMEOUT) ? CLK_PER_STEP : TIMEOUT;
    localparam int TMR_W   = $clog2(TMR_MAX);

    // Terminal counts: the timer runs 0..N-1 so each phase lasts exactly N cycles.
    localparam logic [TMR_W-1:0]   ON_LAST   = TMR_W'(CLK_PER_STEP - 1);
    localparam logic [TMR_W-1:0]   OFF_LAST  = TMR_W'(CLK_PER_STEP / 2 - 1);
    localparam logic [TMR_W-1:0]   TO_LAST   = TMR_W'(TIMEOUT - 1);
    localparam logic [SCORE_W-1:0] SCORE_WIN = SCORE_W'(MAX_LEN);
    localparam logic [NUM_CH-1:0]  ONE_CH    = NUM_CH'(1);

    state_t state;
    state_t state_nxt;

    logic [15:0]        lfsr_q;
    logic [IDX_W-1:0]   new_elem;

    logic               start_q;
    logic               start_prev;
    logic               start_rise;
    logic [NUM_CH-1:0]  btn_q;
    logic [NUM_CH-1:0]  btn_prev;
    logic [NUM_CH-1:0]  btn_rise;
    logic               btn_multi;

    logic [IDX_W-1:0]   seq [MAX_LEN];
    logic [SCORE_W-1:0] score;
    logic [SCORE_W-1:0] idx;
    logic [SCORE_W-1:0] high_score;
    logic [TMR_W-1:0]   tmr;
    logic               flash;
    logic [NUM_CH-1:0]  cur_oh;

    // Datapath strobes from the FSM.
    logic score_clr;
    logic score_inc;
    logic idx_clr;
    logic idx_inc;
    logic tmr_clr;
    logic seq_wr;
    logic flash_set;
    logic flash_tgl;
    logic hs_upd;

    lfsr16 u_lfsr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .o_q     (lfsr_q)
    );

    assign new_elem   = IDX_W'(lfsr_q % 16'(NUM_CH));

    // Inputs are registered once (cur) and once more (prev); a rise is cur & ~prev.
    assign start_rise = start_q & ~start_prev;
    assign btn_rise   = btn_q & ~btn_prev;
    // More than one bit set: clearing the lowest set bit leaves something behind.
    assign btn_multi  = (btn_rise & (btn_rise - ONE_CH)) != '0;

    // Channel of the element currently being shown or expected from the player.
    assign cur_oh     = ONE_CH << seq[idx];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        score_clr = 1'b0;
        score_inc = 1'b0;
        idx_clr   = 1'b0;
        idx_inc   = 1'b0;
        tmr_clr   = 1'b0;
        seq_wr    = 1'b0;
        flash_set = 1'b0;
        flash_tgl = 1'b0;
        hs_upd    = 1'b0;

        case (state)
            IDLE, LOSE: begin
                if (start_rise) begin
                    state_nxt = ADD;
                    score_clr = 1'b1;
                end
            end

            WIN: begin
                if (start_rise) begin
                    state_nxt = ADD;
                    score_clr = 1'b1;
                end else if (tmr == ON_LAST) begin
                    tmr_clr   = 1'b1;
                    flash_tgl = 1'b1;
                end
            end

            ADD: begin
                seq_wr    = 1'b1;
                idx_clr   = 1'b1;
                tmr_clr   = 1'b1;
                state_nxt = SHOW_ON;
            end

            SHOW_ON: begin
                if (tmr == ON_LAST) begin
                    tmr_clr   = 1'b1;
                    state_nxt = SHOW_OFF;
                end
            end

            SHOW_OFF: begin
                if (tmr == OFF_LAST) begin
                    tmr_clr = 1'b1;
                    if (idx == score) begin
                        idx_clr   = 1'b1;
                        state_nxt = WAIT_IN;
                    end else begin
                        idx_inc   = 1'b1;
                        state_nxt = SHOW_ON;
                    end
                end
            end

            WAIT_IN: begin
                // A press in the expiry cycle takes priority over the timeout.
                if (btn_rise != '0) begin
                    if (btn_multi || (btn_rise != cur_oh)) begin
                        hs_upd    = 1'b1;
                        state_nxt = LOSE;
                    end else if (idx == score) begin
                        score_inc = 1'b1;
                        state_nxt = RELEASE;
                    end else begin
                        idx_inc = 1'b1;
                        tmr_clr = 1'b1;
                    end
                end else if (tmr == TO_LAST) begin
                    hs_upd    = 1'b1;
                    state_nxt = LOSE;
                end
            end

            RELEASE: begin
                if (btn_q == '0) begin
                    if (score == SCORE_WIN) begin
                        hs_upd    = 1'b1;
                        tmr_clr   = 1'b1;
                        flash_set = 1'b1;
                        state_nxt = WIN;
                    end else begin
                        state_nxt = ADD;
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            start_q    <= 1'b0;
            start_prev <= 1'b0;
            btn_q      <= '0;
            btn_prev   <= '0;
            score      <= '0;
            idx        <= '0;
            high_score <= '0;
            tmr        <= '0;
            flash      <= 1'b0;
        end else begin
            start_q    <= i_start;
            start_prev <= start_q;
            btn_q      <= i_btn;
            btn_prev   <= btn_q;

            if (score_clr) begin
                score <= '0;
            end else if (score_inc) begin
                score <= score + SCORE_W'(1);
            end

            if (idx_clr) begin
                idx <= '0;
            end else if (idx_inc) begin
                idx <= idx + SCORE_W'(1);
            end

            // Free-runs outside timed states; every timed state clears it on entry.
            if (tmr_clr) begin
                tmr <= '0;
            end else begin
                tmr <= tmr + TMR_W'(1);
            end

            if (flash_set) begin
                flash <= 1'b1;
            end else if (flash_tgl) begin
                flash <= ~flash;
            end

            // score already holds its final value when WIN/LOSE is entered.
            if (hs_upd && (score > high_score)) begin
                high_score <= score;
            end
        end
    end

    // Sequence memory survives reset; only ADD writes it, at the current round.
    always_ff @(posedge i_clk) begin
        if (seq_wr) begin
            seq[score] <= new_elem;
        end
    end

    always_comb begin
        o_led = '0;
        case (state)
            SHOW_ON: o_led = cur_oh;
            WAIT_IN: o_led = btn_q;
            WIN:     o_led = {NUM_CH{flash}};
            default: o_led = '0;
        endcase
    end

    assign o_score      = score;
    assign o_high_score = high_score;
    assign o_busy       = !((state == IDLE) || (state == WIN) || (state == LOSE));
    assign o_win        = (state == WIN);
    assign o_lose       = (state == LOSE);

endmodule

// File: tb/tb_memory_game_core.sv
module tb_memory_game_core;

    typedef struct {
        int         cyc;
        logic [3:0] led;
        logic [3:0] lmask;
        logic [1:0] score;
        logic [1:0] hs;
        logic       busy;
        logic       win;
        logic       lose;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] btn = 4'b0;
    logic [3:0] led;
    logic [1:0] score;
    logic [1:0] hs;
    logic       busy;
    logic       win;
    logic       lose;

    int         cyc = 0;
    int         n_tests = 0;
    int         n_fail = 0;
    int         hs_m = 0;
    int         seq_m [8];
    logic [15:0] m = 16'hACE1;

    exp_t       sb [$];
    string      tq [$];

    memory_game_core #(
        .NUM_CH       (4),
        .MAX_LEN      (3),
        .CLK_PER_STEP (4),
        .TIMEOUT      (20)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_btn        (btn),
        .o_led        (led),
        .o_score      (score),
        .o_high_score (hs),
        .o_busy       (busy),
        .o_win        (win),
        .o_lose       (lose)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference Galois LFSR (taps 16,14,13,11) in lockstep with the reset.
    always @(posedge clk) begin
        if (!rst_n) m <= 16'hACE1;
        else        m <= m[0] ? ((m >> 1) ^ 16'hB400) : (m >> 1);
    end

    // Monitor: compares outputs against the expectation queued for this cycle.
    exp_t  e_mon;
    string t_mon;
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e_mon = sb.pop_front();
            t_mon = tq.pop_front();
            n_tests++;
            if (e_mon.cyc != cyc
                || (led & e_mon.lmask) !== (e_mon.led & e_mon.lmask)
                || score !== e_mon.score || hs !== e_mon.hs
                || busy !== e_mon.busy || win !== e_mon.win || lose !== e_mon.lose) begin
                n_fail++;
                $display("FAIL %s @%0d: got led=%h score=%0d hs=%0d busy=%b win=%b lose=%b, want led=%h/%h score=%0d hs=%0d busy=%b win=%b lose=%b",
                         t_mon, cyc, led, score, hs, busy, win, lose,
                         e_mon.led, e_mon.lmask, e_mon.score, e_mon.hs, e_mon.busy, e_mon.win, e_mon.lose);
            end
        end
    end

    function automatic logic [3:0] oh(input int c);
        logic [3:0] one;
        one = 4'b0001;
        return one << c;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] l, input logic [3:0] lmask,
                       input int s, input logic b, input logic w, input logic lo);
        exp_t e;
        e.cyc   = cyc;
        e.led   = l;
        e.lmask = lmask;
        e.score = 2'(s);
        e.hs    = 2'(hs_m);
        e.busy  = b;
        e.win   = w;
        e.lose  = lo;
        sb.push_back(e);
        tq.push_back(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        hs_m  = 0;
        tick(3);
        chk("rst_hold", 4'h0, 4'hF, 0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick(1);
        chk("rst_release", 4'h0, 4'hF, 0, 1'b0, 1'b0, 1'b0);
    endtask

    // Rise on i_start in the current cycle; returns at the ADD cycle (t+2).
    task automatic start_game();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(1);
    endtask

    // Called in the ADD cycle of round s; returns in the first WAIT_IN cycle.
    task automatic play(input int s);
        seq_m[s] = int'(m[1:0]);
        chk("add", 4'h0, 4'hF, s, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i <= s; i++) begin
            tick(1);
            chk("show_on_first", oh(seq_m[i]), 4'hF, s, 1'b1, 1'b0, 1'b0);
            tick(3);
            chk("show_on_last", oh(seq_m[i]), 4'hF, s, 1'b1, 1'b0, 1'b0);
            tick(1);
            chk("show_off", 4'h0, 4'hF, s, 1'b1, 1'b0, 1'b0);
            tick(1);
        end
        tick(1);
        chk("wait_entry", 4'h0, 4'hF, s, 1'b1, 1'b0, 1'b0);
    endtask

    // Called in the first WAIT_IN cycle; presses 5 cycles apart, returns at the next ADD/WIN cycle.
    task automatic mirror(input int s);
        for (int j = 0; j <= s; j++) begin
            btn = oh(seq_m[j]);
            tick(1);
            chk("echo", oh(seq_m[j]), 4'hF, s, 1'b1, 1'b0, 1'b0);
            tick(1);
            if (j < s) begin
                chk("press_ok", oh(seq_m[j]), 4'hF, s, 1'b1, 1'b0, 1'b0);
                btn = 4'b0;
                tick(3);
            end else begin
                chk("round_done", 4'h0, 4'h0, s + 1, 1'b1, 1'b0, 1'b0);
                btn = 4'b0;
                tick(2);
            end
        end
    endtask

    initial begin
        // 1: reset values, buttons ignored in IDLE
        do_reset();
        btn = 4'b0001;
        tick(1);
        chk("idle_btn", 4'h0, 4'hF, 0, 1'b0, 1'b0, 1'b0);
        btn = 4'b0;
        tick(2);
        chk("idle_btn_after", 4'h0, 4'hF, 0, 1'b0, 1'b0, 1'b0);

        // 2: full win over three rounds
        start_game();
        play(0); mirror(0);
        play(1); mirror(1);
        play(2); mirror(2);
        hs_m = 3;
        chk("win_on_first", 4'hF, 4'hF, 3, 1'b0, 1'b1, 1'b0);
        tick(3);
        chk("win_on_last", 4'hF, 4'hF, 3, 1'b0, 1'b1, 1'b0);
        tick(1);
        chk("win_off_first", 4'h0, 4'hF, 3, 1'b0, 1'b1, 1'b0);
        tick(3);
        chk("win_off_last", 4'h0, 4'hF, 3, 1'b0, 1'b1, 1'b0);
        tick(1);
        chk("win_on_again", 4'hF, 4'hF, 3, 1'b0, 1'b1, 1'b0);

        // 3: wrong channel loses
        start_game();
        play(0);
        btn = oh((seq_m[0] + 1) % 4);
        tick(1);
        chk("wrong_echo", oh((seq_m[0] + 1) % 4), 4'hF, 0, 1'b1, 1'b0, 1'b0);
        tick(1);
        btn = 4'b0;
        chk("lose_wrong", 4'h0, 4'hF, 0, 1'b0, 1'b0, 1'b1);

        // 4: timeout exactly 20 cycles after WAIT_IN entry
        start_game();
        play(0);
        tick(19);
        chk("timeout_minus1", 4'h0, 4'hF, 0, 1'b1, 1'b0, 1'b0);
        tick(1);
        chk("timeout_lose", 4'h0, 4'hF, 0, 1'b0, 1'b0, 1'b1);
        // press judged in the expiry cycle wins over the timeout
        start_game();
        play(0);
        tick(18);
        btn = oh(seq_m[0]);
        tick(2);
        chk("late_press", 4'h0, 4'h0, 1, 1'b1, 1'b0, 1'b0);
        btn = 4'b0;
        tick(2);
        play(1);
        tick(20);
        chk("timeout_s1", 4'h0, 4'hF, 1, 1'b0, 1'b0, 1'b1);

        // 5: multi-press loss and high-score retention
        do_reset();
        start_game();
        play(0); mirror(0);
        play(1); mirror(1);
        play(2);
        btn = oh(seq_m[0]) | oh((seq_m[0] + 1) % 4);
        tick(2);
        btn = 4'b0;
        hs_m = 2;
        chk("lose_multi", 4'h0, 4'hF, 2, 1'b0, 1'b0, 1'b1);
        start_game();
        play(0); mirror(0);
        play(1);
        btn = oh((seq_m[0] + 1) % 4);
        tick(2);
        btn = 4'b0;
        chk("lose_s1_keep_hs", 4'h0, 4'hF, 1, 1'b0, 1'b0, 1'b1);

        // 6: reset during SHOW_ON, then a normal new game
        start_game();
        seq_m[0] = int'(m[1:0]);
        tick(2);
        chk("show_pre_rst", oh(seq_m[0]), 4'hF, 0, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        hs_m  = 0;
        tick(1);
        chk("mid_rst", 4'h0, 4'hF, 0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick(1);
        start_game();
        play(0); mirror(0);
        chk("restart_add", 4'h0, 4'hF, 1, 1'b1, 1'b0, 1'b0);

        tick(1);
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_fail += sb.size();
            $display("FAIL scoreboard_drain: %0d expectations left unchecked, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
